// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: bundles the requester-side bus and the flash engine
// chipset bus of flash_arbiter.
//   master: requesters + flash engine view (drive req/addr and the engine's
//           ready/busy/dout; observe ack/rdata/status and flash_addr/flash_cs)
//   slave : arbiter view (the mirror image)
// Signals:
//   req[NREQ]       level read request per requester
//   addr[NREQ*24]   packed byte addresses, requester i at [24i+23:24i]
//   ack[NREQ]       one-cycle data-valid pulse per requester
//   rdata[8]        read byte shared by all requesters
//   active          a transfer is in progress
//   retries[8]      saturating count of timeout retries
//   flash_ready/flash_busy/flash_dout  engine status and read data
//   flash_addr/flash_cs                engine address and start trigger
interface flash_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] addr;
  logic [NREQ-1:0]    ack;
  logic [7:0]         rdata;
  logic               active;
  logic [7:0]         retries;
  logic               flash_ready;
  logic               flash_busy;
  logic [7:0]         flash_dout;
  logic [23:0]        flash_addr;
  logic               flash_cs;

  modport master (
    output req, addr, flash_ready, flash_busy, flash_dout,
    input  ack, rdata, active, retries, flash_addr, flash_cs
  );

  modport slave (
    input  req, addr, flash_ready, flash_busy, flash_dout,
    output ack, rdata, active, retries, flash_addr, flash_cs
  );
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one SPI flash read engine between NREQ byte-read
// requesters. Grants one requester at a time, raises flash_cs to start the
// engine, retries when the engine does not respond with busy within TMO
// cycles, and returns the byte with a one-cycle ack.
// Ports:
//   clk     system clock, shared with the flash engine
//   resetn  asynchronous active-low reset
//   bus     flash_arbiter_if.slave (requester bus + engine bus + status)
// Parameters:
//   NREQ  number of requesters (2..8)
//   TMO   cycles to wait for flash_busy after flash_cs rises (4..255)
// Configuration macro:
//   FLASH_ARB_RR_EN  defined: round-robin arbitration starting at a pointer
//                    that advances past the last-served requester.
//                    undefined: fixed priority, lowest index wins.
module flash_arbiter #(
  parameter int NREQ = 3,
  parameter int TMO  = 15
) (
  input  logic           clk,
  input  logic           resetn,
  flash_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, BACKOFF, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [23:0]     flash_addr_q, flash_addr_d;
  logic            flash_cs_q, flash_cs_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      retries_q, retries_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   win_idx;

`ifdef FLASH_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps; the first requester found wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
        found   = 1'b1;
        win_idx = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Pointer moves past the requester just served, during its ack cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE) begin
      ptr_d = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scanning downwards leaves the lowest requesting index.
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) win_idx = IW'(k);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    flash_addr_d = flash_addr_q;
    flash_cs_d   = flash_cs_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    retries_d    = retries_q;
    ack_d        = '0;
    case (state_q)
      IDLE: begin
        if (bus.flash_ready && !bus.flash_busy && (bus.req != '0)) begin
          idx_d        = win_idx;
          flash_addr_d = bus.addr[24*int'(win_idx) +: 24];
          flash_cs_d   = 1'b1;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.flash_busy) begin
          flash_cs_d = 1'b0;
          state_d    = XFER;
        end else if (cnt_q == 8'(TMO)) begin
          // Engine missed the edge: drop cs and try again after a clean low.
          flash_cs_d = 1'b0;
          if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
          cnt_d   = '0;
          state_d = BACKOFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BACKOFF: begin
        if (cnt_q == 8'd2) begin
          flash_cs_d = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      XFER: begin
        if (!bus.flash_busy) begin
          rdata_d = bus.flash_dout;
          ack_d   = NREQ'(1) << idx_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      flash_addr_q <= '0;
      flash_cs_q   <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      retries_q    <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      flash_addr_q <= flash_addr_d;
      flash_cs_q   <= flash_cs_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      retries_q    <= retries_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.active     = (state_q != IDLE);
  assign bus.retries    = retries_q;
  assign bus.flash_addr = flash_addr_q;
  assign bus.flash_cs   = flash_cs_q;
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed scenarios followed by randomized traffic.
// A behavioural flash engine answers cs edges; a monitor predicts each grant
// from the sampled requests, queues the expected ack/data and checks them
// whenever the arbiter acks.
module tb_flash_arbiter;
  localparam int NREQ = 3;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  flash_arbiter_if #(.NREQ(NREQ)) bus();

  flash_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  // engine controls
  int ign_next  = 0;
  int ign_total = 0;
  bit rand_ign  = 1'b0;

  function automatic logic [7:0] fdata(logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD5;
  endfunction

  function automatic int pick(logic [NREQ-1:0] r, int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [NREQ-1:0] a);
    for (int i = 0; i < NREQ; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tmo_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  task automatic set_addr(int i, logic [23:0] a);
    bus.addr[24*i +: 24] = a;
  endtask

  task automatic wait_cs_high();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.flash_cs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo_fail("wait_cs");
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    bit ok;
    ok = 1'b0;
    a  = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a  = bus.ack;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo_fail("wait_ack");
  endtask

  // Behavioural flash engine: on a cs rising edge, raise busy after 1..4
  // cycles, hold it 5..21 cycles with garbage on dout, then present data.
  initial begin
    int e_phase, e_cnt;
    logic e_cs_prev;
    logic [23:0] e_addr;
    e_phase = 0; e_cnt = 0; e_cs_prev = 1'b0; e_addr = '0;
    bus.flash_busy = 1'b0;
    bus.flash_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) ign_total = 0;
      case (e_phase)
        0: if (bus.flash_cs && !e_cs_prev) begin
          if (ign_next > 0 || (rand_ign && $urandom_range(0, 7) == 0)) begin
            if (ign_next > 0) ign_next--;
            ign_total++;
          end else begin
            e_phase = 1;
            e_cnt   = $urandom_range(0, 3);
          end
        end
        1: if (e_cnt == 0) begin
          bus.flash_busy = 1'b1;
          e_addr         = bus.flash_addr;
          bus.flash_dout = ~fdata(e_addr);
          e_cnt          = $urandom_range(4, 20);
          e_phase        = 2;
        end else e_cnt--;
        default: if (e_cnt == 0) begin
          bus.flash_busy = 1'b0;
          bus.flash_dout = fdata(e_addr);
          e_phase        = 0;
        end else e_cnt--;
      endcase
      e_cs_prev = bus.flash_cs;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic            cs_p, ready_p, busy_p, busy_p2, in_txn;
    logic [NREQ-1:0] req_p;
    logic [NREQ*24-1:0] addr_p;
    int m_ptr, win;
    exp_t e;
    cs_p = 0; ready_p = 0; busy_p = 0; busy_p2 = 0; in_txn = 0;
    req_p = '0; addr_p = '0; m_ptr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        in_txn = 1'b0;
        m_ptr  = 0;
      end else begin
        if (bus.flash_cs && !cs_p && !in_txn) begin
          check("grant_cond", {29'd0, ready_p, busy_p, (req_p != '0)}, 32'd5);
          win = pick(req_p, m_ptr);
          if (win >= 0) begin
            check("grant_addr", bus.flash_addr, addr_p[24*win +: 24]);
            check("grant_active", bus.active, 1);
            e.idx  = win;
            e.data = fdata(addr_p[24*win +: 24]);
            exp_q.push_back(e);
`ifdef FLASH_ARB_RR_EN
            m_ptr = (win + 1) % NREQ;
`endif
          end
          in_txn = 1'b1;
        end
        if (bus.ack != '0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got %0b want none", bus.ack);
          end else begin
            e = exp_q.pop_front();
            $display("ack req=%0d data=%02h", onehot_idx(bus.ack), bus.rdata);
            check("ack_vec", bus.ack, 32'(1) << e.idx);
            check("ack_data", bus.rdata, e.data);
            check("ack_after_busy_fall", {30'd0, busy_p2, busy_p}, 32'd2);
          end
          in_txn = 1'b0;
        end
      end
      busy_p2 = busy_p;
      busy_p  = bus.flash_busy;
      cs_p    = bus.flash_cs;
      ready_p = bus.flash_ready;
      req_p   = bus.req;
      addr_p  = bus.addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [NREQ-1:0] a;
    int got[6];
    int cnt, lowcnt, nack, ncs, idle_cyc;
    bit ok;

    bus.req = '0;
    bus.addr = '0;
    bus.flash_ready = 1'b0;

    // reset values
    #3 resetn = 1'b0;
    #1;
    check("rst_ack", bus.ack, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_active", bus.active, 0);
    check("rst_retries", bus.retries, 0);
    check("rst_flash_addr", bus.flash_addr, 0);
    check("rst_flash_cs", bus.flash_cs, 0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // init phase: no grant while engine not ready
    @(posedge clk); #1;
    set_addr(0, 24'h000777);
    bus.req = 3'b001;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      check("init_cs", bus.flash_cs, 0);
      check("init_ack", bus.ack, 0);
    end
    @(posedge clk); #1 bus.flash_ready = 1'b1;
    @(negedge clk);
    check("cs_before_grant", bus.flash_cs, 0);
    @(negedge clk);
    check("cs_grant", bus.flash_cs, 1);
    wait_ack(a);
    @(posedge clk); #1 bus.req = '0;

    // single read
    set_addr(1, 24'h123456);
    bus.req = 3'b010;
    wait_cs_high();
    check("single_flash_addr", bus.flash_addr, 32'h123456);
    wait_ack(a);
    check("single_ack", a, 3'b010);
    check("single_rdata", bus.rdata, 8'hA5);
    @(posedge clk); #1 bus.req = '0;
    @(negedge clk);
    check("single_ack_one_cycle", bus.ack, 0);

    // contention after a reset so the pointer starts at 0
    @(negedge clk); #1 resetn = 1'b0;
    @(negedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_addr(i, 24'h100000 + 24'(i * 24'h010203));
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(a);
      got[k] = onehot_idx(a);
    end
    @(posedge clk); #1 bus.req = '0;
    for (int k = 0; k < 6; k++) begin
`ifdef FLASH_ARB_RR_EN
      check("contention_order", got[k], k % 3);
`else
      check("contention_order", got[k], 0);
`endif
    end

    // withdrawal before grant
    @(posedge clk); #1;
    bus.flash_ready = 1'b0;
    set_addr(2, 24'h2468AC);
    bus.req = 3'b100;
    repeat (5) @(posedge clk);
    #1 bus.req = '0;
    bus.flash_ready = 1'b1;
    nack = 0; ncs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ack != '0) nack++;
      if (bus.flash_cs) ncs++;
    end
    check("withdraw_pre_acks", nack, 0);
    check("withdraw_pre_cs", ncs, 0);

    // withdrawal after grant
    @(posedge clk); #1 bus.req = 3'b100;
    wait_cs_high();
    @(posedge clk); #1 bus.req = '0;
    wait_ack(a);
    check("withdraw_post_ack", a, 3'b100);
    nack = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.ack != '0) nack++;
    end
    check("withdraw_post_extra_acks", nack, 0);

    // timeout / retry
    @(posedge clk); #1;
    ign_next = 1;
    set_addr(0, 24'hABCDEF);
    bus.req = 3'b001;
    wait_cs_high();
    cnt = 1;
    ok  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!bus.flash_cs) begin ok = 1'b1; break; end
      cnt++;
    end
    if (!ok) tmo_fail("retry_cs_fall");
    check("retry_cs_high_cycles", cnt, TMO + 1);
    lowcnt = 1;
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.flash_cs) begin ok = 1'b1; break; end
      lowcnt++;
    end
    if (!ok) tmo_fail("retry_cs_rise");
    check("retry_cs_low_cycles", lowcnt, 3);
    wait_ack(a);
    check("retry_ack", a, 3'b001);
    check("retry_rdata", bus.rdata, fdata(24'hABCDEF));
    check("retry_count", bus.retries, 1);
    @(posedge clk); #1 bus.req = '0;

    // reset during XFER
    @(posedge clk); #1;
    set_addr(1, 24'h0F1E2D);
    bus.req = 3'b010;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.flash_busy && !bus.flash_cs && bus.active) begin ok = 1'b1; break; end
    end
    if (!ok) tmo_fail("reach_xfer");
    #1 resetn = 1'b0;
    bus.req = '0;
    #1;
    check("midrst_ack", bus.ack, 0);
    check("midrst_rdata", bus.rdata, 0);
    check("midrst_active", bus.active, 0);
    check("midrst_retries", bus.retries, 0);
    check("midrst_flash_addr", bus.flash_addr, 0);
    check("midrst_flash_cs", bus.flash_cs, 0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    nack = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ack != '0) nack++;
    end
    check("midrst_no_ack", nack, 0);

    // randomized traffic
    rand_ign = 1'b1;
    idle_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else set_addr(i, 24'($urandom));
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_addr(i, 24'($urandom));
            bus.req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      if (bus.ack != '0 || bus.req == '0) idle_cyc = 0;
      else idle_cyc++;
      if (idle_cyc > 400) begin
        tmo_fail("random_progress");
        break;
      end
    end
    @(posedge clk); #1 bus.req = '0;
    rand_ign = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.active) begin ok = 1'b1; break; end
    end
    if (!ok) tmo_fail("drain");
    check("drain_queue_empty", exp_q.size(), 0);
    check("random_retries", bus.retries, (ign_total > 255) ? 255 : ign_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
